// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: address width, reset PC and address type.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/pc_reg_if.sv
// Next-PC / current-PC bus between the next-address logic and the PC register.
interface pc_reg_if #(
  parameter int WIDTH = cpu_pkg::ADDR_W
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (output data_in, input data_out);
  modport slave  (input data_in, output data_out);

endinterface

// File: rtl/dff_sr.sv
// Generic WIDTH-bit D flip-flop with synchronous active-low reset to RST_VAL.
module dff_sr #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pc_reg.sv
// Program-counter register: captures next-PC each rising edge, sync active-low reset.
// Optional macro PC_ALIGN_EN forces the captured value and reset vector word aligned.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VECTOR = RESET_PC
) (
  input  logic    clk,
  input  logic    rst,
  pc_reg_if.slave bus
);

`ifdef PC_ALIGN_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
`else
  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}};
`endif

  // The reset vector goes through the same mask so a reset PC is always fetchable.
  localparam logic [WIDTH-1:0] RST_PC = RESET_VECTOR & ALIGN_MASK;

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  always_comb begin
    pc_d = bus.data_in & ALIGN_MASK;
  end

  dff_sr #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_PC)
  ) u_pc_ff (
    .clk (clk),
    .rst (rst),
    .d   (pc_d),
    .q   (pc_q)
  );

  assign bus.data_out = pc_q;

endmodule

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: table of {rst, data_in, expected} plus timed corner sequences.
module tb_pc_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_reg_if #(.WIDTH(32)) bus ();

  pc_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{"load_100",   1'b1, 32'd100,       32'd100};
    vecs[1] = '{"load_50",    1'b1, 32'd50,        32'd50};
    vecs[2] = '{"load_200",   1'b1, 32'd200,       32'd200};
    vecs[3] = '{"rst_midrun", 1'b0, 32'd300,       32'd0};
    vecs[4] = '{"release",    1'b1, 32'd400,       32'd400};
`ifdef PC_ALIGN_EN
    vecs[5] = '{"all_ones",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[6] = '{"align_103",  1'b1, 32'h0000_0103, 32'h0000_0100};
    vecs[7] = '{"pattern",    1'b1, 32'h1234_5679, 32'h1234_5678};
`else
    vecs[5] = '{"all_ones",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6] = '{"align_103",  1'b1, 32'h0000_0103, 32'h0000_0103};
    vecs[7] = '{"pattern",    1'b1, 32'h1234_5679, 32'h1234_5679};
`endif
    vecs[8] = '{"zero",       1'b1, 32'h0000_0000, 32'h0000_0000};

    // Hold in reset with data_in moving underneath (edges at 50, 150, 250 ns).
    rst = 1'b0;
    bus.data_in = 32'd0;
    #51;  check("hold_rst_e1", bus.data_out, 32'd0);
    #49;  bus.data_in = 32'd100;
    #30;  bus.data_in = 32'd50;
    #21;  check("hold_rst_e2", bus.data_out, 32'd0);
    #50;  check("hold_rst_mid", bus.data_out, 32'd0);
    #50;  check("hold_rst_e3", bus.data_out, 32'd0);

    // Vector table: drive on the falling edge, sample 1 ns after the rising edge.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.data_in = vecs[i].din;
      @(posedge clk);
      #1;
      check(vecs[i].name, bus.data_out, vecs[i].exp);
    end

    // Mid-cycle glitch: only the value present at the edge is captured.
    @(negedge clk);
    rst = 1'b1;
    bus.data_in = 32'd7;
    #10; bus.data_in = 32'd9;
    #10; check("glitch_stable", bus.data_out, 32'd0);
    bus.data_in = 32'd12;
    @(posedge clk); #1;
    check("glitch_capture", bus.data_out, 32'd12);
    #20; bus.data_in = 32'd5;
    #28; check("no_comb_path", bus.data_out, 32'd12);
    @(posedge clk); #1;
    check("after_glitch", bus.data_out, 32'd5);

    // Reset mid-run, then release mid-cycle: PC holds reset value until the next edge.
    @(negedge clk);
    bus.data_in = 32'd200;
    @(posedge clk); #1;
    check("pre_rst_200", bus.data_out, 32'd200);
    @(negedge clk);
    rst = 1'b0;
    bus.data_in = 32'd300;
    @(posedge clk); #1;
    check("rst_to_vector", bus.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.data_in = 32'd444;
    #20; check("rst_release_mid", bus.data_out, 32'd0);
    @(posedge clk); #1;
    check("load_after_rel", bus.data_out, 32'd444);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
